// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller for the EX stage.
// Owns the HI/LO registers and sequences fixed-latency mult/div operations.
// Optional build macro: MDU_FLUSH_EN adds a 'flush' input that aborts an
// in-flight operation or cancels a same-cycle command.
//
// Command handshake: a command is taken on a rising edge when start=1 with a
// valid op (1..6) while busy=0. While busy=1 every command (including
// mthi/mtlo) is dropped, so the issuing stage must hold it until busy=0.
// mult/div results and busy=0 become visible together on the cycle after the
// final busy cycle.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic            sgn_q, sgn_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic            flush_i;

`ifdef MDU_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Result datapath, evaluated from the latched operands only.
    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
    logic        b_zero;

    // Multiplier and sign-magnitude divider; low 64 bits of the extended
    // product are correct for both signed and unsigned operands.
    always_comb begin
        mul_a  = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        mul_b  = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod   = mul_a * mul_b;
        a_mag  = (sgn_q && a_q[31]) ? (~a_q + 32'd1) : a_q;
        b_mag  = (sgn_q && b_q[31]) ? (~b_q + 32'd1) : b_q;
        b_zero = (b_q == 32'd0);
        q_mag  = b_zero ? 32'd0 : (a_mag / b_mag);
        r_mag  = b_zero ? 32'd0 : (a_mag % b_mag);
        // Quotient negated when signs differ; remainder follows the dividend.
        // 0x80000000 / -1 wraps naturally to quotient 0x80000000, remainder 0.
        quot   = (sgn_q && (a_q[31] ^ b_q[31])) ? (~q_mag + 32'd1) : q_mag;
        rem    = (sgn_q && a_q[31]) ? (~r_mag + 32'd1) : r_mag;
    end

    // Next-state, counter, operand latch and HI/LO update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush_i) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            a_d     = A;
                            b_d     = B;
                            sgn_d   = (op == OP_MULT);
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d     = A;
                            b_d     = B;
                            sgn_d   = (op == OP_DIV);
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = S_DIV;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (flush_i) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (state_q == S_MUL) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (!b_zero) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and architectural registers; reset aborts any in-flight op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl with hand-computed expected values.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        flush;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_vec;
    int n_err;

    mdu_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
`ifdef MDU_FLUSH_EN
        .flush(flush),
`endif
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    // Clock: 10 time-unit period, rising edge is the active edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a command for one edge; returns in cycle T+1 with start low.
    task automatic issue(input logic [2:0] c_op, input logic [31:0] c_a, input logic [31:0] c_b);
        start = 1'b1;
        op    = c_op;
        A     = c_a;
        B     = c_b;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
    endtask

    // Check busy for n cycles, then check the committed result.
    task automatic wait_result(input string tag, input int n, input logic [31:0] exp_hi,
                               input logic [31:0] exp_lo);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_hi"}, HI, exp_hi);
        check({tag, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        flush = 1'b0;
        A     = 32'd0;
        B     = 32'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Signed mult: -2 * 3 = -6
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_result("mult_s", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // Unsigned mult: 0xFFFFFFFE * 3 = 0x2_FFFFFFFA
        issue(3'd2, 32'hFFFF_FFFE, 32'd3);
        wait_result("mult_u", 5, 32'h0000_0002, 32'hFFFF_FFFA);

        // mthi: single-cycle, never busy
        issue(3'd5, 32'h0000_1234, 32'd0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_hi", HI, 32'h0000_1234);
        check("mthi_lo", LO, 32'hFFFF_FFFA);

        // Signed mult of -1 * -1 and unsigned of the same bit patterns
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("mult_s_nn", 5, 32'h0000_0000, 32'h0000_0001);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("mult_u_max", 5, 32'hFFFF_FFFE, 32'h0000_0001);

        // Signed divide: -7 / 2 = -3 rem -1
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_s", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Unsigned divide: 7 / 2 = 3 rem 1
        issue(3'd4, 32'd7, 32'd2);
        wait_result("div_u", 10, 32'd1, 32'd3);

        // Signed overflow: 0x80000000 / -1
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_ovf", 10, 32'd0, 32'h8000_0000);

        // Unsigned divide of a large value that would be negative if signed
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_u_big", 10, 32'd1, 32'h7FFF_FFFC);

        // Preload HI/LO, then divide by zero with commands issued while busy
        issue(3'd5, 32'h0000_00AA, 32'd0);
        issue(3'd6, 32'h0000_00BB, 32'd0);
        check("pre_hi", HI, 32'h0000_00AA);
        check("pre_lo", LO, 32'h0000_00BB);
        issue(3'd3, 32'h0000_0123, 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("dz_busy", {31'd0, busy}, 32'd1);
            if (i == 2) begin
                start = 1'b1; op = 3'd6; A = 32'h0000_0055; B = 32'd0;
            end else if (i == 5) begin
                start = 1'b1; op = 3'd1; A = 32'd3; B = 32'd5;
            end else begin
                start = 1'b0; op = 3'd0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        op    = 3'd0;
        for (int i = 0; i < 3; i++) begin
            check("dz_idle", {31'd0, busy}, 32'd0);
            check("dz_hi", HI, 32'h0000_00AA);
            check("dz_lo", LO, 32'h0000_00BB);
            @(negedge clk);
        end

        // Reset in the middle of a multiply
        issue(3'd1, 32'd5, 32'd6);
        @(negedge clk);
        @(negedge clk);
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_hi", HI, 32'd0);
        check("mid_rst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        issue(3'd4, 32'd20, 32'd6);
        wait_result("post_rst_div", 10, 32'd2, 32'd3);

`ifdef MDU_FLUSH_EN
        // Flush a divide in cycle T+4
        issue(3'd4, 32'd100, 32'd7);
        for (int i = 0; i < 3; i++) begin
            check("fl_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        check("fl_busy_t4", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_idle", {31'd0, busy}, 32'd0);
        check("fl_hi", HI, 32'd2);
        check("fl_lo", LO, 32'd3);
        @(negedge clk);
        check("fl_still_idle", {31'd0, busy}, 32'd0);

        // Start with flush in IDLE: mthi and div both cancelled
        flush = 1'b1;
        issue(3'd5, 32'h0000_0999, 32'd0);
        check("fl_mthi_hi", HI, 32'd2);
        issue(3'd3, 32'd50, 32'd5);
        flush = 1'b0;
        check("fl_div_busy", {31'd0, busy}, 32'd0);
        check("fl_div_lo", LO, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
